// File: rtl/coin_return_timer.sv
// ---------------------------------------------------------------------------
// coin_return_timer
//
// Purpose:
//   This is the control FSM for a vending-machine coin changer.
//   - Coin or item activity arms an inactivity timer.
//   - A return request, or a timeout when TIMEOUT_RETURN_EN is defined,
//     latches the live balance and tells the datapath to clear it.
//   - The latched balance is then paid out largest-coin-first, one coin
//     per cycle.
//   - Whatever is smaller than the smallest coin is left in o_residue.
//
// Optional feature (macro TIMEOUT_RETURN_EN):
//   - Defined: a timeout in ARMED with a non-zero balance starts a return,
//     exactly as a trigger would.
//   - Undefined (default): a timeout only drops ARMED back to IDLE.
//
// Ports:
//   clk              clock; all state updates on its rising edge
//   reset_n          synchronous reset, ACTIVE-HIGH despite the name
//   i_input_coin     per-denomination coin-insert strobes
//   o_output_item    item-dispensed strobes from the item datapath
//   i_trigger_return user return request (level or pulse)
//   current_total    live balance from the datapath
//   coin_value       flattened 32-bit denomination values, strictly
//                    ascending with the slice index
//   o_return_coin    one-hot coin-eject strobe (registered)
//   o_total_clear    one-cycle pulse ordering the datapath to zero its balance
//   o_busy           high while the FSM is paying out (RETURN state)
//   wait_time        remaining inactivity cycles
//   o_residue        unreturnable remainder of the last return
// ---------------------------------------------------------------------------
module coin_return_timer #(
  parameter int NUM_COINS  = 3,
  parameter int NUM_ITEMS  = 4,
  parameter int TOTAL_BITS = 16,
  parameter int WAIT_TIME  = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_COINS-1:0]    i_input_coin,
  input  logic [NUM_ITEMS-1:0]    o_output_item,
  input  logic                    i_trigger_return,
  input  logic [TOTAL_BITS-1:0]   current_total,
  input  logic [NUM_COINS*32-1:0] coin_value,
  output logic [NUM_COINS-1:0]    o_return_coin,
  output logic                    o_total_clear,
  output logic                    o_busy,
  output logic [31:0]             wait_time,
  output logic [TOTAL_BITS-1:0]   o_residue
);

  // Comparisons run at the wider of the balance and denomination widths,
  // so neither operand is ever truncated.
  localparam int CW = (TOTAL_BITS > 32) ? TOTAL_BITS : 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RETURN = 2'd2
  } state_t;

  state_t                state;
  logic [TOTAL_BITS-1:0] remaining;
  logic [NUM_COINS-1:0]  coin_sel;
  logic                  activity;
  logic                  start_return;
  logic                  timeout_return;

  function automatic logic [CW-1:0] coin_val(
    input int                    idx,
    input logic [NUM_COINS*32-1:0] cv
  );
    return CW'(cv[32*idx +: 32]);
  endfunction

  // Values ascend with the index, so the last fitting index is the largest
  // coin that fits. Returns all zeros when nothing fits.
  function automatic logic [NUM_COINS-1:0] pick_coin(
    input logic [TOTAL_BITS-1:0]   rem,
    input logic [NUM_COINS*32-1:0] cv
  );
    logic [NUM_COINS-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (coin_val(i, cv) <= CW'(rem)) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

  // The selected coin value never exceeds rem, so this cannot underflow.
  function automatic logic [TOTAL_BITS-1:0] pay_out(
    input logic [TOTAL_BITS-1:0]   rem,
    input logic [NUM_COINS-1:0]    sel,
    input logic [NUM_COINS*32-1:0] cv
  );
    logic [CW-1:0] amount;
    amount = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (sel[i]) amount = coin_val(i, cv);
    end
    return TOTAL_BITS'(CW'(rem) - amount);
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

  assign activity     = (|i_input_coin) | (|o_output_item);
  assign start_return = i_trigger_return && (current_total != '0);
  assign coin_sel     = pick_coin(remaining, coin_value);
  assign o_busy       = (state == RETURN);

`ifdef TIMEOUT_RETURN_EN
  assign timeout_return = (state == ARMED) && (wait_time == 32'd0) &&
                          (current_total != '0);
`else
  assign timeout_return = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state         <= IDLE;
      wait_time     <= 32'd0;
      o_return_coin <= '0;
      o_total_clear <= 1'b0;
      o_residue     <= '0;
      remaining     <= '0;
    end else begin
      o_total_clear <= 1'b0;
      case (state)
        IDLE, ARMED: begin
          o_return_coin <= '0;
          // A return request wins over simultaneous coin/item activity.
          if (start_return || timeout_return) begin
            state         <= RETURN;
            remaining     <= current_total;
            o_total_clear <= 1'b1;
            wait_time     <= 32'd0;
          end else if (activity) begin
            state     <= ARMED;
            wait_time <= 32'(WAIT_TIME);
          end else if (state == ARMED) begin
            wait_time <= sat_dec(wait_time);
            if (wait_time == 32'd0) state <= IDLE;
          end
        end
        RETURN: begin
          // Strobes and triggers are deliberately ignored while paying out.
          if (coin_sel != '0) begin
            o_return_coin <= coin_sel;
            remaining     <= pay_out(remaining, coin_sel, coin_value);
          end else begin
            state         <= IDLE;
            o_return_coin <= '0;
            o_residue     <= remaining;
          end
        end
        default: begin
          state         <= IDLE;
          o_return_coin <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_return_timer.sv
// ---------------------------------------------------------------------------
// tb_coin_return_timer
//
// Directed, self-checking bench for coin_return_timer.
// - Configuration: coin values 100/500/1000 and WAIT_TIME = 10.
// - Timing: inputs are driven 1 time unit after a rising edge, and outputs
//   are checked at that same point.
// - TIMEOUT_RETURN_EN selects which timeout behaviour is expected.
// ---------------------------------------------------------------------------
module tb_coin_return_timer;

  localparam int NC = 3;
  localparam int NI = 4;
  localparam int TB = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NC-1:0]   coin;
  logic [NI-1:0]   item;
  logic            trig;
  logic [TB-1:0]   total;
  logic [NC*32-1:0] cval;
  logic [NC-1:0]   ret_coin;
  logic            tclr;
  logic            busy;
  logic [31:0]     wt;
  logic [TB-1:0]   residue;

  int total_cnt = 0;
  int bad = 0;

  coin_return_timer #(
    .NUM_COINS (NC),
    .NUM_ITEMS (NI),
    .TOTAL_BITS(TB),
    .WAIT_TIME (10)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_input_coin    (coin),
    .o_output_item   (item),
    .i_trigger_return(trig),
    .current_total   (total),
    .coin_value      (cval),
    .o_return_coin   (ret_coin),
    .o_total_clear   (tclr),
    .o_busy          (busy),
    .wait_time       (wt),
    .o_residue       (residue)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks the three payout outputs together: coin strobe, clear pulse, busy.
  task automatic chk_out(input string tag, input logic [NC-1:0] c,
                         input logic clr, input logic b);
    chk({tag, ".coin"}, 32'(ret_coin), 32'(c));
    chk({tag, ".clr"},  32'(tclr),     32'(clr));
    chk({tag, ".busy"}, 32'(busy),     32'(b));
  endtask

  initial begin
    reset_n = 1'b1;
    coin    = '0;
    item    = '0;
    trig    = 1'b0;
    total   = '0;
    cval    = {32'd1000, 32'd500, 32'd100};

    // Reset state
    tick();
    tick();
    chk_out("rst", 3'b000, 1'b0, 1'b0);
    chk("rst.wait", wt, 32'd0);
    chk("rst.res", 32'(residue), 32'd0);
    reset_n = 1'b0;
    tick();

    // Countdown after a single coin insert: 10 down to 0, then saturate
    coin = 3'b010;
    tick();
    coin = '0;
    chk("arm.wait10", wt, 32'd10);
    for (int k = 9; k >= 0; k--) begin
      tick();
      chk($sformatf("arm.wait%0d", k), wt, 32'(k));
    end
    tick();
    chk("arm.sat0", wt, 32'd0);
    chk_out("arm.idle", 3'b000, 1'b0, 1'b0);

    // 1600 return: clear pulse, then 1000, 500, 100, residue 0
    total = 16'd1600;
    trig  = 1'b1;
    tick();
    trig  = 1'b0;
    total = '0;
    chk_out("r1600.entry", 3'b000, 1'b1, 1'b1);
    tick(); chk_out("r1600.c0", 3'b100, 1'b0, 1'b1);
    tick(); chk_out("r1600.c1", 3'b010, 1'b0, 1'b1);
    tick(); chk_out("r1600.c2", 3'b001, 1'b0, 1'b1);
    tick(); chk_out("r1600.end", 3'b000, 1'b0, 1'b0);
    chk("r1600.res", 32'(residue), 32'd0);

    // 1650 return leaves 50 as residue
    total = 16'd1650;
    trig  = 1'b1;
    tick();
    trig  = 1'b0;
    total = '0;
    chk_out("r1650.entry", 3'b000, 1'b1, 1'b1);
    tick(); chk_out("r1650.c0", 3'b100, 1'b0, 1'b1);
    tick(); chk_out("r1650.c1", 3'b010, 1'b0, 1'b1);
    tick(); chk_out("r1650.c2", 3'b001, 1'b0, 1'b1);
    tick(); chk_out("r1650.end", 3'b000, 1'b0, 1'b0);
    chk("r1650.res", 32'(residue), 32'd50);

    // Reset after the first ejected coin aborts the return; residue is cleared
    coin = 3'b001;
    tick();
    coin = '0;
    chk("abort.armed", wt, 32'd10);
    total = 16'd1600;
    trig  = 1'b1;
    tick();
    trig  = 1'b0;
    total = '0;
    chk_out("abort.entry", 3'b000, 1'b1, 1'b1);
    chk("abort.waitclr", wt, 32'd0);
    tick(); chk_out("abort.c0", 3'b100, 1'b0, 1'b1);
    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
    chk_out("abort.rst", 3'b000, 1'b0, 1'b0);
    chk("abort.res", 32'(residue), 32'd0);
    chk("abort.wait", wt, 32'd0);
    tick(); chk_out("abort.after1", 3'b000, 1'b0, 1'b0);
    tick(); chk_out("abort.after2", 3'b000, 1'b0, 1'b0);

    // A trigger with a zero balance does nothing
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk_out("zero.trig", 3'b000, 1'b0, 1'b0);
    chk("zero.wait", wt, 32'd0);

    // Coin strobes and a repeated trigger during RETURN are ignored
    total = 16'd1600;
    trig  = 1'b1;
    tick();
    total = '0;
    chk_out("ign.entry", 3'b000, 1'b1, 1'b1);
    coin = 3'b001;
    item = 4'b0010;
    tick();
    chk_out("ign.c0", 3'b100, 1'b0, 1'b1);
    chk("ign.wait0", wt, 32'd0);
    tick();
    chk_out("ign.c1", 3'b010, 1'b0, 1'b1);
    trig = 1'b0;
    coin = '0;
    item = '0;
    tick(); chk_out("ign.c2", 3'b001, 1'b0, 1'b1);
    tick(); chk_out("ign.end", 3'b000, 1'b0, 1'b0);
    chk("ign.wait1", wt, 32'd0);

    // A trigger beats simultaneous activity
    total = 16'd500;
    trig  = 1'b1;
    coin  = 3'b100;
    tick();
    trig  = 1'b0;
    coin  = '0;
    total = '0;
    chk_out("prio.entry", 3'b000, 1'b1, 1'b1);
    chk("prio.wait", wt, 32'd0);
    tick(); chk_out("prio.c0", 3'b010, 1'b0, 1'b1);
    tick(); chk_out("prio.end", 3'b000, 1'b0, 1'b0);

    // Timeout with a balance pending: return only with TIMEOUT_RETURN_EN
    total = 16'd500;
    item  = 4'b1000;
    tick();
    item  = '0;
    chk("to.arm", wt, 32'd10);
    for (int k = 0; k < 10; k++) tick();
    chk("to.wait0", wt, 32'd0);
    chk_out("to.armed", 3'b000, 1'b0, 1'b0);
    tick();
`ifdef TIMEOUT_RETURN_EN
    total = '0;
    chk_out("to.entry", 3'b000, 1'b1, 1'b1);
    tick(); chk_out("to.c0", 3'b010, 1'b0, 1'b1);
    tick(); chk_out("to.end", 3'b000, 1'b0, 1'b0);
`else
    chk_out("to.idle", 3'b000, 1'b0, 1'b0);
    tick(); chk_out("to.idle1", 3'b000, 1'b0, 1'b0);
    tick(); chk_out("to.idle2", 3'b000, 1'b0, 1'b0);
    total = '0;
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad);
    $finish;
  end

endmodule
